// File: rtl/dac_sample_buffer.sv
// DAC playback buffer: sample FIFO drained at a programmable rate, with
// IDLE/PRIME/RUN playback control and sticky underflow accounting.
module dac_sample_buffer #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned PRIME_LEVEL = 8
) (
    input  logic                     DAC_clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [15:0]              rate_div,
    input  logic [9:0]               s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic                     clear_status,
    output logic [9:0]               DAC_data,
    output logic                     sample_strobe,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     underflow,
    output logic [15:0]              underflow_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] PRIME_LVL = LW'(PRIME_LEVEL);
    localparam logic [9:0]    MIDSCALE  = 10'h200;

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t          state_q;
    logic [15:0]     rate_cnt_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [LW-1:0]   level_q;
    logic [LW-1:0]   level_d;
    logic [9:0]      dac_q;
    logic            uf_q;
    logic [15:0]     uf_cnt_q;
    logic [9:0]      mem_q [DEPTH];

    logic push_d;
    logic pop_d;
    logic uf_event_d;

    // Strobe uses >= so a rate_div reduced below the running count ends the
    // current slot once instead of letting the counter run through 16'hFFFF.
    assign sample_strobe = (state_q == RUN) && (rate_cnt_q >= rate_div);
    assign s_ready       = (level_q != DEPTH_LVL);
    assign fifo_level    = level_q;
    assign DAC_data      = dac_q;
    assign underflow     = uf_q;
    assign underflow_cnt = uf_cnt_q;

    always_comb begin
        push_d     = s_valid && s_ready;
        pop_d      = sample_strobe && (level_q != '0);
        uf_event_d = sample_strobe && (level_q == '0);
        level_d    = level_q;
        if (push_d && !pop_d) begin
            level_d = level_q + LW'(1);
        end else if (!push_d && pop_d) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge DAC_clk) begin
        if (push_d) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    always_ff @(posedge DAC_clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rate_cnt_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            dac_q      <= MIDSCALE;
            uf_q       <= 1'b0;
            uf_cnt_q   <= '0;
        end else begin
            if (push_d) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_d) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q <= level_d;

            // A pop in the cycle enable drops still consumes the sample,
            // but the output returns to midscale.
            if (!enable || state_q == IDLE) begin
                dac_q <= MIDSCALE;
            end else if (pop_d) begin
                dac_q <= mem_q[rd_ptr_q];
            end

            if (!enable) begin
                state_q    <= IDLE;
                rate_cnt_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q    <= PRIME;
                        rate_cnt_q <= '0;
                    end
                    PRIME: begin
                        if (level_q >= PRIME_LVL) begin
                            state_q <= RUN;
                        end
                        rate_cnt_q <= '0;
                    end
                    RUN: begin
                        rate_cnt_q <= sample_strobe ? '0 : rate_cnt_q + 16'd1;
                    end
                    default: begin
                        state_q    <= IDLE;
                        rate_cnt_q <= '0;
                    end
                endcase
            end

            if (uf_event_d) begin
                uf_q     <= 1'b1;
                uf_cnt_q <= clear_status ? 16'd1 :
                            (uf_cnt_q == '1) ? uf_cnt_q : uf_cnt_q + 16'd1;
            end else if (clear_status) begin
                uf_q     <= 1'b0;
                uf_cnt_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dac_sample_buffer.sv
// Self-checking bench for dac_sample_buffer: directed scenarios plus a random
// phase, all compared against a queue-based playback model.
module tb_dac_sample_buffer;

    localparam int DEPTH = 16;
    localparam int PRIME = 8;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int M_IDLE  = 0;
    localparam int M_PRIME = 1;
    localparam int M_RUN   = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [15:0]   rate_div;
    logic [9:0]    s_data;
    logic          s_valid;
    logic          s_ready;
    logic          clear_status;
    logic [9:0]    DAC_data;
    logic          sample_strobe;
    logic [LW-1:0] fifo_level;
    logic          underflow;
    logic [15:0]   underflow_cnt;

    int checks   = 0;
    int failures = 0;

    // Playback model: sample queue, mode, slot position and status.
    int q[$];
    int m_mode;
    int m_cnt;
    int m_dac;
    int m_uf;
    int m_ufcnt;

    dac_sample_buffer #(.DEPTH(DEPTH), .PRIME_LEVEL(PRIME)) dut (
        .DAC_clk      (clk),
        .reset        (reset),
        .enable       (enable),
        .rate_div     (rate_div),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .clear_status (clear_status),
        .DAC_data     (DAC_data),
        .sample_strobe(sample_strobe),
        .fifo_level   (fifo_level),
        .underflow    (underflow),
        .underflow_cnt(underflow_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_mode  = M_IDLE;
        m_cnt   = 0;
        m_dac   = 'h200;
        m_uf    = 0;
        m_ufcnt = 0;
    endtask

    task automatic check_reset_values(input string pfx);
        chk({pfx, "_dac"},    DAC_data, 'h200);
        chk({pfx, "_level"},  fifo_level, 0);
        chk({pfx, "_strobe"}, sample_strobe, 0);
        chk({pfx, "_uflag"},  underflow, 0);
        chk({pfx, "_ucnt"},   underflow_cnt, 0);
    endtask

    // One clock cycle: apply inputs, check outputs, advance the model.
    task automatic step(input bit en, input int rd, input bit v, input int d, input bit clr);
        int  lvl;
        int  popped;
        int  nmode;
        bit  strobe_e;
        bit  has_pop;
        bit  uf_ev;
        bit  push_e;
        @(negedge clk);
        enable       = en;
        rate_div     = rd[15:0];
        s_valid      = v;
        s_data       = d[9:0];
        clear_status = clr;
        #1;
        lvl      = q.size();
        strobe_e = (m_mode == M_RUN) && (m_cnt >= rd);
        chk("dac",    DAC_data, m_dac);
        chk("level",  fifo_level, lvl);
        chk("ready",  s_ready, int'(lvl < DEPTH));
        chk("strobe", sample_strobe, int'(strobe_e));
        chk("uflag",  underflow, m_uf);
        chk("ucnt",   underflow_cnt, m_ufcnt);

        push_e  = v && (lvl < DEPTH);
        has_pop = 0;
        uf_ev   = 0;
        popped  = 0;
        if (strobe_e) begin
            if (lvl > 0) begin
                popped  = q.pop_front();
                has_pop = 1;
            end else begin
                uf_ev = 1;
            end
        end
        if (push_e) q.push_back(d & 'h3FF);

        if (!en)          m_dac = 'h200;
        else if (has_pop) m_dac = popped;

        if (!en)                    nmode = M_IDLE;
        else if (m_mode == M_IDLE)  nmode = M_PRIME;
        else if (m_mode == M_PRIME) nmode = (lvl >= PRIME) ? M_RUN : M_PRIME;
        else                        nmode = M_RUN;
        m_cnt  = (m_mode == M_RUN && nmode == M_RUN) ? (strobe_e ? 0 : m_cnt + 1) : 0;
        m_mode = nmode;

        if (uf_ev) begin
            m_uf    = 1;
            m_ufcnt = clr ? 1 : ((m_ufcnt == 'hFFFF) ? m_ufcnt : m_ufcnt + 1);
        end else if (clr) begin
            m_uf    = 0;
            m_ufcnt = 0;
        end
        @(posedge clk);
    endtask

    initial begin
        int rd_cur;
        int pv;
        reset        = 1'b1;
        enable       = 1'b0;
        rate_div     = '0;
        s_data       = '0;
        s_valid      = 1'b0;
        clear_status = 1'b0;
        model_reset();
        #2;
        check_reset_values("rst");
        chk("rst_ready", s_ready, 1);
        #5 reset = 1'b0;

        // Ramp 0..7 at rate_div=3, then drain into underflow.
        for (int i = 0; i < 8; i++) step(1, 3, 1, i, 0);
        for (int i = 0; i < 40; i++) step(1, 3, 0, 0, 0);

        // Fill while idle with 17 offers; the 17th waits for a pop.
        step(0, 3, 0, 0, 1);
        for (int i = 0; i < 17; i++) step(0, 2, 1, 'h100 + i, 0);
        chk("full_level", fifo_level, DEPTH);
        chk("full_ready", s_ready, 0);
        for (int i = 0; i < 6; i++) step(1, 2, 1, 'h110, 0);
        for (int i = 0; i < 40; i++) step(1, 2, 0, 0, 0);

        // Fast drain with rate_div=0, underflow every cycle, then clears.
        for (int i = 0; i < 6; i++) step(0, 0, 1, 'h2A0 + i, 0);
        for (int i = 0; i < 30; i++) step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        chk("clr_uflag", underflow, 0);
        chk("clr_ucnt",  underflow_cnt, 0);

        // Enable drop mid-run, then re-enable with a primed FIFO.
        for (int i = 0; i < 12; i++) step(1, 1, 1, 'h050 + i, 0);
        for (int i = 0; i < 6; i++)  step(1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++)  step(0, 1, 1, 'h070 + i, 0);
        for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 0);

        // Random traffic, enable toggles, clears and rate changes.
        rd_cur = 1;
        pv     = 50;
        for (int i = 0; i < 600; i++) begin
            if (i % 100 == 0) pv = (i % 300 == 0) ? 20 : ((i % 200 == 0) ? 90 : 55);
            if ($urandom_range(0, 19) == 0) rd_cur = $urandom_range(0, 5);
            step(($urandom_range(0, 15) != 0), rd_cur,
                 ($urandom_range(0, 99) < pv), $urandom_range(0, 1023),
                 ($urandom_range(0, 24) == 0));
        end

        // Full FIFO in RUN, then asynchronous reset between edges.
        step(0, 1000, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 1000, 1, 'h300 + i, 0);
        for (int i = 0; i < 3; i++)  step(1, 1000, 0, 0, 0);
        chk("prerst_level", fifo_level, DEPTH);
        #3 reset = 1'b1;
        #1;
        model_reset();
        check_reset_values("arst");
        chk("arst_ready", s_ready, 1);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step(1, 0, 1, 'h3F0 + i, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dac_sample_buffer.md
DAC_SAMPLE_BUFFER -- requirements
Module: dac_sample_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16: FIFO depth in samples, power of two, 4..256.
REQ-002 SHALL have parameter PRIME_LEVEL, default 8: FIFO level required before playback starts, 1..DEPTH.
REQ-003 SHALL have port DAC_clk, input, 1 bit: sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1 bit: playback enable; level-sensitive.
REQ-006 SHALL have port rate_div, input, 16 bits: output sample period minus one, in DAC_clk cycles.
REQ-007 SHALL have port s_data, input, 10 bits: upstream sample, unsigned offset-binary.
REQ-008 SHALL have port s_valid, input, 1 bit: s_data valid.
REQ-009 SHALL have port s_ready, output, 1 bit: buffer can accept a sample.
REQ-010 SHALL have port clear_status, input, 1 bit: single-cycle pulse clearing the underflow status.
REQ-011 SHALL have port DAC_data, output, 10 bits: registered sample to the DAC.
REQ-012 SHALL have port sample_strobe, output, 1 bit: one-cycle pulse each output sample slot.
REQ-013 SHALL have port fifo_level, output, log2(DEPTH)+1 bits: current FIFO occupancy.
REQ-014 SHALL have port underflow, output, 1 bit: sticky flag, set on any empty-slot event.
REQ-015 SHALL have port underflow_cnt, output, 16 bits: count of empty slots, saturating at 16'hFFFF.

Function
REQ-016 SHALL accept a sample when s_valid and s_ready are both high on a rising edge; s_ready SHALL equal not-full, combinationally from registered state.
REQ-017 SHALL never drop or duplicate an accepted sample; FIFO order SHALL be preserved; FIFO contents SHALL persist across enable toggles.
REQ-018 SHALL implement three states: IDLE, PRIME, RUN.
REQ-019 IDLE: rate counter held at 0, no strobes, DAC_data driven to midscale 10'h200; enable high moves to PRIME.
REQ-020 PRIME: no strobes, DAC_data holds; fifo_level >= PRIME_LEVEL moves to RUN with rate counter at 0.
REQ-021 RUN: rate counter counts 0..rate_div, wrapping to 0; sample_strobe SHALL be high in the cycle the counter equals rate_div.
REQ-022 rate_div=0 SHALL give a strobe every cycle; changes to rate_div SHALL take effect at the next comparison, with no glitch strobe.
REQ-023 On a strobe with FIFO non-empty: pop head; DAC_data SHALL equal that sample on the following edge (1-cycle latency).
REQ-024 On a strobe with FIFO empty: DAC_data SHALL hold its last value; underflow SHALL set; underflow_cnt SHALL increment (saturating); state stays RUN.
REQ-025 Push and strobe in the same cycle with FIFO empty: underflow event SHALL occur and the pushed sample SHALL be stored (fifo_level becomes 1).
REQ-026 Push and pop in the same cycle with FIFO non-empty and not full: fifo_level SHALL be unchanged.
REQ-027 FIFO full: s_ready SHALL be low, including the cycle a pop occurs; it SHALL rise on the edge after the pop.
REQ-028 enable low in any state SHALL move to IDLE on the next edge; DAC_data SHALL become 10'h200 on that edge; a strobe in that cycle SHALL still pop.
REQ-029 clear_status SHALL clear underflow and underflow_cnt; a coincident underflow event SHALL take priority (flag set, count = 1).
REQ-030 Pointer arithmetic SHALL wrap modulo DEPTH; fifo_level SHALL range 0..DEPTH.

Reset
REQ-031 On reset high, asynchronously: state IDLE, FIFO empty, fifo_level 0, rate counter 0, DAC_data 10'h200, sample_strobe 0, underflow 0, underflow_cnt 0.
REQ-032 s_ready SHALL be high from the first edge after reset deasserts; reset mid-operation SHALL discard FIFO contents.

Verification
REQ-033 Reset, enable=1, rate_div=3, push 8 ramp samples 0..7 -> RUN after the 8th push; strobe every 4 cycles; DAC_data 0,1,2,... each 1 cycle after its strobe.
REQ-034 DEPTH=16, hold off strobes, push 17 samples -> s_ready low after the 16th; the 17th is not accepted until after a pop; fifo_level = 16.
REQ-035 RUN with 2 samples, no further pushes, rate_div=0 -> 2 pops, then DAC_data holds 2nd sample, underflow=1, underflow_cnt increments every cycle.
REQ-036 Pulse clear_status with no coincident slot -> underflow=0, underflow_cnt=0; with coincident empty slot -> underflow=1, cnt=1.
REQ-037 Drop enable mid-RUN -> DAC_data=10'h200 next edge; strobes stop; re-enable with fifo_level >= PRIME_LEVEL -> PRIME, then RUN on the next edge.
REQ-038 Assert reset mid-RUN with a full FIFO -> all outputs at REQ-031 values immediately, with no clock required.
